shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 35 +++
 rtl/shift_step.sv | 56 +++++
 rtl/shift_sequencer.sv | 122 ++++++++++++
 tb/tb_shift_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings and constants for the multi-cycle shift sequencer.
// Rotate support is selected at build time by SHIFT_SEQ_ROTATE_EN.
package shift_sequencer_pkg;

    localparam int DATA_W     = 32;
    localparam int SHAMT_W    = 5;
    localparam int STEP_W     = 3;
    localparam int STEP_MAX_C = 7;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Distance to shift this cycle: the smaller of what is left and the per-cycle limit.
    function automatic logic [STEP_W-1:0] clip_step(input logic [SHAMT_W-1:0] rem,
                                                    input logic [SHAMT_W-1:0] lim);
        logic [STEP_W-1:0] step;
        if (rem > lim) begin
            step = lim[STEP_W-1:0];
        end else begin
            step = rem[STEP_W-1:0];
        end
        return step;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational 32-bit shift by 0..7 built from three 2:1 mux stages (1, 2, 4).
// Rotate fill is only built when SHIFT_SEQ_ROTATE_EN is defined; otherwise OP_ROL shifts left.
module shift_step
    import shift_sequencer_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  amt,
    input  logic [1:0]  op,
    input  logic        fill,
    output logic [31:0] shifted
);

    logic [31:0] stage1_s;
    logic [31:0] stage2_s;
    logic [31:0] stage4_s;

    // One mux stage: pass data through or shift it by a fixed distance n.
    function automatic logic [31:0] stage_shift(input logic [31:0] d,
                                                input logic        en,
                                                input int unsigned n,
                                                input op_e         o,
                                                input logic        f);
        logic [31:0] r;
        logic [31:0] fill_mask;
        if (f) begin
            fill_mask = ~(32'hFFFF_FFFF >> n);
        end else begin
            fill_mask = 32'h0000_0000;
        end
        case (o)
            OP_SLL:  r = d << n;
            OP_SRL:  r = d >> n;
            OP_SRA:  r = (d >> n) | fill_mask;
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROL:  r = (d << n) | (d >> (32 - n));
`else
            OP_ROL:  r = d << n;
`endif
            default: r = d << n;
        endcase
        if (en) begin
            return r;
        end else begin
            return d;
        end
    endfunction

    // Cascade the 1-, 2- and 4-bit stages.
    always_comb begin
        stage1_s = stage_shift(data,     amt[0], 1, op_e'(op), fill);
        stage2_s = stage_shift(stage1_s, amt[1], 2, op_e'(op), fill);
        stage4_s = stage_shift(stage2_s, amt[2], 4, op_e'(op), fill);
        shifted  = stage4_s;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: accepts an operation, shifts up to STEP_MAX bits per cycle,
// then pulses done with the result. Define SHIFT_SEQ_ROTATE_EN to enable op=11 rotate-left.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int STEP_MAX = STEP_MAX_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dataIn,
    input  logic [4:0]  shAmt,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    state_e       state_r;
    state_e       state_next_s;
    logic [31:0]  work_r;
    logic [31:0]  work_next_s;
    logic [4:0]   remaining_r;
    logic [4:0]   remaining_next_s;
    logic [1:0]   op_r;
    logic [1:0]   op_next_s;
    logic         fill_r;
    logic         fill_next_s;
    logic [2:0]   step_s;
    logic [31:0]  shifted_s;
    logic [31:0]  result_r;
    logic         done_r;
    logic         ready_r;
    logic         busy_r;

    assign step_s = clip_step(remaining_r, 5'(STEP_MAX));

    shift_step u_shift_step (
        .data    (work_r),
        .amt     (step_s),
        .op      (op_r),
        .fill    (fill_r),
        .shifted (shifted_s)
    );

    // Next-state and datapath update for IDLE -> SHIFT* -> DONE -> IDLE.
    always_comb begin
        state_next_s     = state_r;
        work_next_s      = work_r;
        remaining_next_s = remaining_r;
        op_next_s        = op_r;
        fill_next_s      = fill_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    work_next_s      = dataIn;
                    remaining_next_s = shAmt;
                    op_next_s        = op;
                    fill_next_s      = dataIn[31];
                    if (shAmt == 5'd0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_next_s      = shifted_s;
                remaining_next_s = remaining_r - {2'b00, step_s};
                if (remaining_next_s == 5'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; result loads only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            work_r      <= 32'h0000_0000;
            remaining_r <= 5'd0;
            op_r        <= 2'b00;
            fill_r      <= 1'b0;
            result_r    <= 32'h0000_0000;
            done_r      <= 1'b0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            work_r      <= work_next_s;
            remaining_r <= remaining_next_s;
            op_r        <= op_next_s;
            fill_r      <= fill_next_s;
            if ((state_next_s == ST_DONE) && (state_r != ST_DONE)) begin
                result_r <= work_next_s;
            end else begin
                result_r <= result_r;
            end
            done_r      <= (state_next_s == ST_DONE);
            ready_r     <= (state_next_s == ST_IDLE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    assign ready  = ready_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with an expected-result scoreboard.
// Build with SHIFT_SEQ_ROTATE_EN defined to check the rotate variant of op=11.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dataIn;
    logic [4:0]  shAmt;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    shift_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .dataIn (dataIn),
        .shAmt  (shAmt),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: a whole-distance shift, not the stepped datapath.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
        logic [31:0] r;
        case (o)
            2'b00: r = d << a;
            2'b01: r = d >> a;
            2'b10: r = $signed(d) >>> a;
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11: r = (a == 5'd0) ? d : ((d << a) | (d >> (6'd32 - {1'b0, a})));
`else
            2'b11: r = d << a;
`endif
            default: r = 32'hxxxx_xxxx;
        endcase
        return r;
    endfunction

    // Called #1 after a rising edge; the accept happens on the next edge.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] a, input bit noise);
        exp_t e;
        exp_t got_e;
        int   lat;
        int   busy_n;
        bit   got;
        e.res = model(o, d, a);
        e.lat = (int'(a) + 6) / 7 + 1;
        e.busy_cycles = e.lat;
        sb.push_back(e);
        op = o; dataIn = d; shAmt = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; dataIn = ~d; shAmt = ~a;
        lat = 1; busy_n = 0; got = 1'b0;
        while (!got && lat <= 20) begin
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                start = noise && (lat <= 3);
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check({tag, "_latency"}, lat, got_e.lat);
            check({tag, "_result"}, result, got_e.res);
            check({tag, "_busy_cycles"}, busy_n, got_e.busy_cycles);
        end
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_single_done"}, {31'd0, done}, 32'd0);
        check({tag, "_result_held"}, result, e.res);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; dataIn = 32'h0; shAmt = 5'd0;
        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'h0000_0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 1'b0);
        run_op("sra8", 2'b10, 32'h8000_0000, 5'd8, 1'b0);
        run_op("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 1'b0);
        run_op("sll20_busy_start", 2'b00, 32'h0000_00FF, 5'd20, 1'b1);
        run_op("op11", 2'b11, 32'h8000_0001, 5'd4, 1'b0);

        // Reset mid-operation: abort, no done, result cleared.
        op = 2'b00; dataIn = 32'h0000_00FF; shAmt = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (lat = 1; lat < 2; lat++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0; #1;
        check("midrst_result", result, 32'h0000_0000);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        run_op("after_rst_sra", 2'b10, 32'h8765_4321, 5'd13, 1'b0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
